// File: rtl/uart_pkg.sv
// Shared UART definitions: character width limit and the receive-buffer entry layout.
package uart_pkg;

   localparam int UART_MAX_DATA_BITS = 8;

   typedef struct packed {
      logic       error;
      logic [7:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_rx_buffer_sync_fifo.sv
// First-word-fall-through FIFO with a registered head word and an occupancy count.
module sync_fifo #(
   parameter  int WIDTH = 9,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] head_nxt;

   // The head is registered so it is defined out of reset; a write landing on the
   // next read slot bypasses storage so an empty FIFO shows the entry one edge later.
   always_comb begin
      rd_ptr_nxt = rd_ptr + AW'(pop);
      count_nxt  = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
      head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         if (count_nxt != '0) dout <= head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: done-edge capture, right-justification, FWFT storage, overflow and flush.
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_done,
   input  logic                  rx_error,
   input  logic [3:0]            num_data_bits,
   output logic                  rx_full,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_error,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                  overflow,
   input  logic                  clr_overflow,
   input  logic                  flush
);

   localparam int CW = $clog2(DEPTH) + 1;

   // The receiver shifts LSB-first, so a short character sits in the top bits.
   function automatic logic [DATA_WIDTH-1:0] align_data(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [3:0] n);
      if (n == 4'd0 || n > 4'(UART_MAX_DATA_BITS)) return d;
      return d >> (4'(UART_MAX_DATA_BITS) - n);
   endfunction

   logic      rx_done_d;
   logic      push_req;
   logic      pop;
   logic      full;
   logic      push_drop;
   logic      fifo_push;
   logic      fifo_pop;
   rx_entry_t entry_in;
   rx_entry_t entry_out;

   assign push_req  = rx_done & ~rx_done_d;
   assign full      = (count == CW'(DEPTH));
   assign pop       = out_valid & out_ready;
   assign fifo_push = push_req & (~full | pop) & ~flush;
   assign fifo_pop  = pop & ~flush;
   assign push_drop = push_req & full & ~pop & ~flush;

   assign entry_in.error = rx_error;
   assign entry_in.data  = align_data(rx_data, num_data_bits);

   assign out_valid = (count != '0);
   assign rx_full   = full;
   assign out_data  = entry_out.data;
   assign out_error = entry_out.error;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_done_d <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         rx_done_d <= rx_done;
         if (push_drop)         overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(rx_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (flush),
      .din   (entry_in),
      .dout  (entry_out),
      .count (count)
   );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: directed characters, fill/overflow, flush and reset.
module tb_uart_rx_buffer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_done = 1'b0;
   logic       rx_error = 1'b0;
   logic [3:0] num_data_bits = 4'd8;
   logic       rx_full;
   logic [7:0] out_data;
   logic       out_error;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [4:0] count;
   logic       overflow;
   logic       clr_overflow = 1'b0;
   logic       flush = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx_buffer #(.DEPTH(16), .DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_done       (rx_done),
      .rx_error      (rx_error),
      .num_data_bits (num_data_bits),
      .rx_full       (rx_full),
      .out_data      (out_data),
      .out_error     (out_error),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .count         (count),
      .overflow      (overflow),
      .clr_overflow  (clr_overflow),
      .flush         (flush)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every head accepted by the consumer is compared with the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%0h required=none", {out_error, out_data});
         end else begin
            chk("pop_data", {23'd0, out_error, out_data}, {23'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic err, input logic [3:0] n,
                       input int stop_cycles, input logic expect_push, input logic [8:0] exp);
      @(posedge clk); #1;
      rx_data = d; rx_error = err; num_data_bits = n; rx_done = 1'b1;
      if (expect_push) exp_q.push_back(exp);
      repeat (stop_cycles) @(posedge clk);
      #1 rx_done = 1'b0;
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_count", 32'(count), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_full", 32'(rx_full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_data", {23'd0, out_error, out_data}, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // 8N1 character, one-cycle latency from the done rise
      send(8'hA5, 1'b0, 4'd8, 1, 1'b1, 9'h0A5);
      chk("a5_valid", 32'(out_valid), 1);
      chk("a5_data", 32'(out_data), 32'hA5);
      chk("a5_err", 32'(out_error), 0);
      chk("a5_count", 32'(count), 1);
      drain(1);
      chk("a5_empty", 32'(out_valid), 0);

      send(8'hB8, 1'b0, 4'd5,  1, 1'b1, 9'h017);
      send(8'h5A, 1'b1, 4'd0,  1, 1'b1, 9'h15A);
      send(8'hC3, 1'b0, 4'd12, 1, 1'b1, 9'h0C3);
      send(8'h80, 1'b0, 4'd1,  1, 1'b1, 9'h001);
      send(8'hFE, 1'b0, 4'd7,  1, 1'b1, 9'h07F);
      chk("align_count", 32'(count), 5);
      drain(5);

      // two stop bits: done held two cycles, one entry
      send(8'h3C, 1'b1, 4'd8, 2, 1'b1, 9'h13C);
      @(posedge clk); #1;
      chk("stop2_count", 32'(count), 1);
      drain(1);
      chk("stop2_drained", 32'(count), 0);

      for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 4'd8, 1, 1'b1, {1'b0, 8'(i)});
      chk("fill_full", 32'(rx_full), 1);
      chk("fill_count", 32'(count), 16);
      chk("fill_ovf", 32'(overflow), 0);
      send(8'h10, 1'b0, 4'd8, 1, 1'b0, 9'h0);
      chk("drop_ovf", 32'(overflow), 1);
      chk("drop_count", 32'(count), 16);

      // full with simultaneous pop: the push is accepted
      @(posedge clk); #1;
      rx_data = 8'h55; rx_error = 1'b0; num_data_bits = 4'd8; rx_done = 1'b1; out_ready = 1'b1;
      exp_q.push_back(9'h055);
      @(posedge clk); #1;
      rx_done = 1'b0; out_ready = 1'b0;
      chk("pp_count", 32'(count), 16);
      chk("pp_ovf", 32'(overflow), 1);

      @(posedge clk); #1 clr_overflow = 1'b1;
      @(posedge clk); #1 clr_overflow = 1'b0;
      chk("clr_ovf", 32'(overflow), 0);

      // refused push coincident with clear: set wins
      @(posedge clk); #1;
      rx_data = 8'h77; rx_done = 1'b1; clr_overflow = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0; clr_overflow = 1'b0;
      chk("setclr_ovf", 32'(overflow), 1);

      drain(16);
      chk("wrap_empty", 32'(out_valid), 0);
      chk("wrap_count", 32'(count), 0);

      @(posedge clk); #1 clr_overflow = 1'b1;
      @(posedge clk); #1 clr_overflow = 1'b0;
      for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0, 4'd8, 1, 1'b0, 9'h0);

      // flush on a full FIFO with a push in the same cycle
      @(posedge clk); #1;
      rx_data = 8'h99; rx_done = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0; flush = 1'b0;
      chk("flush_count", 32'(count), 0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_full", 32'(rx_full), 0);
      chk("flush_ovf", 32'(overflow), 0);

      send(8'h42, 1'b0, 4'd8, 1, 1'b1, 9'h042);
      drain(1);

      for (int i = 0; i < 17; i++) send(8'h60 + 8'(i), 1'b0, 4'd8, 1, 1'b0, 9'h0);
      chk("pre_rst_ovf", 32'(overflow), 1);

      // asynchronous reset in the middle of a character
      @(posedge clk); #1 rx_done = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_ovf", 32'(overflow), 0);
      rx_done = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_count", 32'(count), 0);

      send(8'hE7, 1'b1, 4'd8, 1, 1'b1, 9'h1E7);
      drain(1);
      repeat (2) @(posedge clk);
      #1 chk("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
